cordic_sched: RTL

- Round-robin scheduler that shares one CORDIC pipeline instance among NUM_REQ requesters.
- Accepts per-requester valid/ready requests and issues at most one operand triple per cycle into the pipeline.
- Tracks each issued request's requester ID through the fixed pipeline latency and routes the pipeline result back as a one-hot response.
- Provides a drain sequence so software can quiesce the pipeline before reconfiguration.

---
 rtl/cordic_sched.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one fixed-latency CORDIC pipeline among NUM_REQ requesters.
// Optional per-requester issue counters are built when CORDIC_SCHED_STATS_EN is defined.

module cordic_sched #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int PIPE_LATENCY = 8,
    parameter int ID_WIDTH     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_y,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_z,
    output logic                           pipe_in_valid,
    output logic [INPUT_WIDTH-1:0]         pipe_in_x,
    output logic [INPUT_WIDTH-1:0]         pipe_in_y,
    output logic [INPUT_WIDTH-1:0]         pipe_in_z,
    input  logic                           pipe_out_valid,
    input  logic [OUTPUT_WIDTH-1:0]        pipe_out_x,
    input  logic [OUTPUT_WIDTH-1:0]        pipe_out_y,
    input  logic [OUTPUT_WIDTH-1:0]        pipe_out_z,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [OUTPUT_WIDTH-1:0]        rsp_x,
    output logic [OUTPUT_WIDTH-1:0]        rsp_y,
    output logic [OUTPUT_WIDTH-1:0]        rsp_z,
    input  logic                           drain_req,
    output logic                           drain_done,
    output logic                           err_sync
`ifdef CORDIC_SCHED_STATS_EN
    ,
    input  logic                           stat_clr,
    output logic [NUM_REQ*16-1:0]          stat_issue_cnt
`endif
);

    localparam int CNT_W = $clog2(PIPE_LATENCY + 3);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ID_WIDTH-1:0]     ptr_r;
    logic [ID_WIDTH-1:0]     win_s;
    logic                    found_s;
    logic                    grant_en_s;
    logic                    hs_s;
    logic                    done_nxt_s;
    logic                    rsp_any_s;
    logic [NUM_REQ-1:0]      req_ready_s;
    logic                    pipe_in_valid_r;
    logic [INPUT_WIDTH-1:0]  pipe_in_x_r;
    logic [INPUT_WIDTH-1:0]  pipe_in_y_r;
    logic [INPUT_WIDTH-1:0]  pipe_in_z_r;
    logic                    tag_v_r  [PIPE_LATENCY+1];
    logic [ID_WIDTH-1:0]     tag_id_r [PIPE_LATENCY+1];
    logic [NUM_REQ-1:0]      rsp_valid_r;
    logic [OUTPUT_WIDTH-1:0] rsp_x_r;
    logic [OUTPUT_WIDTH-1:0] rsp_y_r;
    logic [OUTPUT_WIDTH-1:0] rsp_z_r;
    logic [CNT_W-1:0]        inflight_r;
    logic [CNT_W-1:0]        inflight_nxt_s;
    logic                    drain_done_r;
    logic                    err_sync_r;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_WIDTH-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first asserted request at or after the pointer
    always_comb begin
        int idx;
        found_s = 1'b0;
        win_s   = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_r) + k;
            idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            if (!found_s && req_valid[idx]) begin
                found_s = 1'b1;
                win_s   = ID_WIDTH'(idx);
            end else begin
                win_s = win_s;
            end
        end
    end

    assign hs_s      = grant_en_s & found_s;
    assign rsp_any_s = |rsp_valid_r;

    // One-hot grant for the winner when granting is enabled
    always_comb begin
        req_ready_s = '0;
        if (hs_s) begin
            req_ready_s[win_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // In-flight count after this cycle's handshake and response
    always_comb begin
        case ({hs_s, rsp_any_s})
            2'b10:   inflight_nxt_s = inflight_r + CNT_W'(1);
            2'b01:   inflight_nxt_s = inflight_r - CNT_W'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Drain FSM next-state; the response retiring this cycle counts as gone
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (drain_req) state_nxt_s = ST_DRAIN;
                else           state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!drain_req)                                state_nxt_s = ST_RUN;
                else if ((inflight_nxt_s == '0) && !hs_s)      state_nxt_s = ST_DONE;
                else                                           state_nxt_s = ST_DRAIN;
            end
            ST_DONE: begin
                if (!drain_req) state_nxt_s = ST_RUN;
                else            state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Drain FSM outputs; a rising drain_req blocks grants in the same cycle
    always_comb begin
        case (state_r)
            ST_RUN:  grant_en_s = !drain_req && !rst;
            default: grant_en_s = 1'b0;
        endcase
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Drain FSM state register and registered done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_RUN;
            drain_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            drain_done_r <= done_nxt_s;
        end
    end

    // Round-robin pointer and in-flight counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r      <= '0;
            inflight_r <= '0;
        end else begin
            if (hs_s) begin
                ptr_r <= (win_s == LAST_ID) ? '0 : win_s + ID_WIDTH'(1);
            end
            inflight_r <= inflight_nxt_s;
        end
    end

    // Issue register: winner's operands the cycle after the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_in_valid_r <= 1'b0;
            pipe_in_x_r     <= '0;
            pipe_in_y_r     <= '0;
            pipe_in_z_r     <= '0;
        end else begin
            pipe_in_valid_r <= hs_s;
            if (hs_s) begin
                pipe_in_x_r <= req_x[win_s*INPUT_WIDTH +: INPUT_WIDTH];
                pipe_in_y_r <= req_y[win_s*INPUT_WIDTH +: INPUT_WIDTH];
                pipe_in_z_r <= req_z[win_s*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    // Tag line: entry k lines up with pipeline stage k, tail with pipe_out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= PIPE_LATENCY; k++) begin
                tag_v_r[k]  <= 1'b0;
                tag_id_r[k] <= '0;
            end
        end else begin
            tag_v_r[0]  <= hs_s;
            tag_id_r[0] <= win_s;
            for (int k = 1; k <= PIPE_LATENCY; k++) begin
                tag_v_r[k]  <= tag_v_r[k-1];
                tag_id_r[k] <= tag_id_r[k-1];
            end
        end
    end

    // Response register routed by the tail tag, not by pipe_out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= '0;
            rsp_x_r     <= '0;
            rsp_y_r     <= '0;
            rsp_z_r     <= '0;
        end else begin
            rsp_valid_r <= tag_v_r[PIPE_LATENCY] ? onehot(tag_id_r[PIPE_LATENCY]) : '0;
            if (tag_v_r[PIPE_LATENCY]) begin
                rsp_x_r <= pipe_out_x;
                rsp_y_r <= pipe_out_y;
                rsp_z_r <= pipe_out_z;
            end
        end
    end

    // Sticky pipeline/tag disagreement flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sync_r <= 1'b0;
        end else if (pipe_out_valid != tag_v_r[PIPE_LATENCY]) begin
            err_sync_r <= 1'b1;
        end
    end

`ifdef CORDIC_SCHED_STATS_EN
    logic [15:0] stat_cnt_r [NUM_REQ];

    // Saturating per-requester handshake counters; clear wins over a handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) stat_cnt_r[i] <= 16'h0000;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) stat_cnt_r[i] <= 16'h0000;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs_s && (int'(win_s) == i) && (stat_cnt_r[i] != 16'hFFFF)) begin
                    stat_cnt_r[i] <= stat_cnt_r[i] + 16'h0001;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_issue_cnt[g*16 +: 16] = stat_cnt_r[g];
    end
`endif

    assign req_ready     = req_ready_s;
    assign pipe_in_valid = pipe_in_valid_r;
    assign pipe_in_x     = pipe_in_x_r;
    assign pipe_in_y     = pipe_in_y_r;
    assign pipe_in_z     = pipe_in_z_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_x         = rsp_x_r;
    assign rsp_y         = rsp_y_r;
    assign rsp_z         = rsp_z_r;
    assign drain_done    = drain_done_r;
    assign err_sync      = err_sync_r;

endmodule
